// File: rtl/vga_sync_receiver_if.sv
// Video link for vga_sync_receiver: raw sync and colour toward the receiver, captured pixel stream back.
interface vga_sync_receiver_if;
    logic       HSYNC;
    logic       VSYNC;
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] B;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [3:0] pix_r;
    logic [3:0] pix_g;
    logic [3:0] pix_b;
    logic       pix_valid;
    logic       frame_start;
    logic       locked;
    logic [7:0] err_cnt;

    modport master (
        output HSYNC, VSYNC, R, G, B,
        input  pix_x, pix_y, pix_r, pix_g, pix_b, pix_valid, frame_start, locked, err_cnt
    );

    modport slave (
        input  HSYNC, VSYNC, R, G, B,
        output pix_x, pix_y, pix_r, pix_g, pix_b, pix_valid, frame_start, locked, err_cnt
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: locks onto HSYNC/VSYNC timing and emits active-area pixels with coordinates.
// Optional macro VGA_SYNC_RECEIVER_ERRCNT_EN enables the saturating loss-of-lock counter on err_cnt.
module vga_sync_receiver #(
    parameter int H_WHOLE     = 800,
    parameter int H_VISIBLE   = 640,
    parameter int H_START     = 144,
    parameter int V_WHOLE     = 525,
    parameter int V_VISIBLE   = 480,
    parameter int V_START     = 35,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    vga_sync_receiver_if.slave vid
);
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam logic [9:0] H_LAST  = 10'(H_WHOLE - 1);
    localparam logic [9:0] H_FIRST = 10'(H_START);
    localparam logic [9:0] H_END   = 10'(H_START + H_VISIBLE - 1);
    localparam logic [9:0] V_LAST  = 10'(V_WHOLE - 1);
    localparam logic [9:0] V_FIRST = 10'(V_START);
    localparam logic [9:0] V_END   = 10'(V_START + V_VISIBLE - 1);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    logic       hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic [3:0] r_q, g_q, b_q;
    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic       vs_pend_q, vs_pend_d, first_edge_q, lines_bad_q;
    logic [7:0] good_q;
    state_t     state_q;
    logic       hs_fall, vs_fall, anchor, line_bad, frame_good, h_sat;
    logic       abort, lock_now, locked_d, active, show;
    logic [9:0] pix_x_q, pix_y_q;
    logic [3:0] pix_r_q, pix_g_q, pix_b_q;
    logic       pix_valid_q, frame_start_q, locked_q;

    // Stage 1: input capture; sync registers idle high so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            hs_q      <= vid.HSYNC;
            hs_prev_q <= hs_q;
            vs_q      <= vid.VSYNC;
            vs_prev_q <= vs_q;
        end
    end

    always_ff @(posedge clk) begin
        r_q <= vid.R;
        g_q <= vid.G;
        b_q <= vid.B;
    end

    always_comb begin
        hs_fall    = hs_prev_q & ~hs_q;
        vs_fall    = vs_prev_q & ~vs_q;
        anchor     = hs_fall & (vs_pend_q | vs_fall);
        vs_pend_d  = anchor ? 1'b0 : (vs_pend_q | vs_fall);
        h_cnt_d    = hs_fall ? 10'd0 : sat_inc(h_cnt_q);
        v_cnt_d    = anchor ? 10'd0 : (hs_fall ? sat_inc(v_cnt_q) : v_cnt_q);
        line_bad   = hs_fall & ~first_edge_q & (h_cnt_q != H_LAST);
        frame_good = ~lines_bad_q & ~line_bad & (v_cnt_q == V_LAST);
        h_sat      = ~hs_fall & (h_cnt_d == 10'h3FF);
        abort      = 1'b0;
        lock_now   = 1'b0;
        case (state_q)
            TRACK: begin
                abort    = line_bad | (anchor & ~frame_good);
                lock_now = anchor & frame_good & ((good_q + 8'd1) == LOCK_N);
            end
            LOCKED:  abort = line_bad | (anchor & ~frame_good) | h_sat;
            default: ;
        endcase
        // locked_d is the state this sample is judged under, so a loss blanks the same pixel
        locked_d = ((state_q == LOCKED) & ~abort) | lock_now;
        active   = (h_cnt_d >= H_FIRST) && (h_cnt_d <= H_END) &&
                   (v_cnt_d >= V_FIRST) && (v_cnt_d <= V_END);
        show     = active & locked_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            vs_pend_q    <= 1'b0;
            first_edge_q <= 1'b1;
            lines_bad_q  <= 1'b0;
            good_q       <= '0;
            state_q      <= SEARCH;
            locked_q     <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            vs_pend_q   <= vs_pend_d;
            lines_bad_q <= anchor ? 1'b0 : (lines_bad_q | line_bad);
            locked_q    <= locked_d;
            if (abort)        first_edge_q <= 1'b1;
            else if (hs_fall) first_edge_q <= 1'b0;
            case (state_q)
                SEARCH: if (anchor) begin
                    state_q <= TRACK;
                    good_q  <= '0;
                end
                TRACK: begin
                    if (abort)         state_q <= SEARCH;
                    else if (lock_now) state_q <= LOCKED;
                    else if (anchor)   good_q  <= good_q + 8'd1;
                end
                LOCKED:  if (abort) state_q <= SEARCH;
                default: state_q <= SEARCH;
            endcase
        end
    end

    // Stage 2: registered pixel outputs; colour forced to zero outside the locked active area
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_valid_q   <= show;
            frame_start_q <= show & (h_cnt_d == H_FIRST) & (v_cnt_d == V_FIRST);
            pix_r_q       <= show ? r_q : 4'd0;
            pix_g_q       <= show ? g_q : 4'd0;
            pix_b_q       <= show ? b_q : 4'd0;
            if (show) begin
                pix_x_q <= h_cnt_d - H_FIRST;
                pix_y_q <= v_cnt_d - V_FIRST;
            end
        end
    end

`ifdef VGA_SYNC_RECEIVER_ERRCNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if ((state_q == LOCKED) && abort && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign vid.err_cnt = err_q;
`else
    assign vid.err_cnt = 8'd0;
`endif

    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.pix_r       = pix_r_q;
    assign vid.pix_g       = pix_g_q;
    assign vid.pix_b       = pix_b_q;
    assign vid.pix_valid   = pix_valid_q;
    assign vid.frame_start = frame_start_q;
    assign vid.locked      = locked_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized bench for vga_sync_receiver on a scaled-down raster (40x20 samples) so whole frames stay short.
module tb_vga_sync_receiver;
    localparam int H_WHOLE     = 40;
    localparam int H_VISIBLE   = 16;
    localparam int H_START     = 12;
    localparam int V_WHOLE     = 20;
    localparam int V_VISIBLE   = 8;
    localparam int V_START     = 5;
    localparam int LOCK_FRAMES = 2;
    localparam int HP          = 4;
    localparam int LONG_LEN    = HP + 1100;
    localparam int S_SEARCH    = 0;
    localparam int S_TRACK     = 1;
    localparam int S_LOCKED    = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vga_sync_receiver_if vif ();

    vga_sync_receiver #(
        .H_WHOLE(H_WHOLE), .H_VISIBLE(H_VISIBLE), .H_START(H_START),
        .V_WHOLE(V_WHOLE), .V_VISIBLE(V_VISIBLE), .V_START(V_START),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vid (vif)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t pend;
    bit   pend_v = 1'b0;

    // Line-level reference: state, good frames, lines since anchor, previous line length
    int m_state = S_SEARCH;
    int m_good = 0;
    int m_lines = 0;
    int m_prev_len = 0;
    bit m_exempt = 1'b1;
    int m_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_lose_lock();
        if (m_state == S_LOCKED) begin
`ifdef VGA_SYNC_RECEIVER_ERRCNT_EN
            if (m_err < 255) m_err++;
`endif
        end
        m_state  = S_SEARCH;
        m_exempt = 1'b1;
    endtask

    task automatic model_line_start(input bit anchor);
        bit line_ok;
        line_ok  = m_exempt || (m_prev_len == H_WHOLE);
        m_exempt = 1'b0;
        if (m_state == S_SEARCH) begin
            if (anchor) begin
                m_state = S_TRACK;
                m_good  = 0;
                m_lines = 0;
            end
        end else if (!line_ok || (anchor && m_lines != V_WHOLE)) begin
            model_lose_lock();
        end else if (anchor) begin
            m_lines = 0;
            if (m_state == S_TRACK) begin
                m_good++;
                if (m_good == LOCK_FRAMES) m_state = S_LOCKED;
            end
        end
        m_lines++;
    endtask

    task automatic send_line(input int len, input int ln, input bit anchor, input bit vs_low,
                             input bit vs_late, input int rst_at);
        bit         geo;
        logic [3:0] cr, cg, cb;
        for (int i = 0; i < len; i++) begin
            if (i == 0) model_line_start(anchor);
            if (i == 1023 && m_state == S_LOCKED) model_lose_lock();
            geo = (i >= H_START) && (i < H_START + H_VISIBLE) &&
                  (ln >= V_START) && (ln < V_START + V_VISIBLE);
            if (geo) begin
                cr = 4'($urandom);
                cg = 4'($urandom);
                cb = 4'($urandom);
            end else begin
                cr = 4'bz;
                cg = 4'bz;
                cb = 4'bz;
            end
            vif.HSYNC = (i < HP) ? 1'b0 : 1'b1;
            vif.VSYNC = (vs_low || (vs_late && i >= len / 2)) ? 1'b0 : 1'b1;
            vif.R = cr;
            vif.G = cg;
            vif.B = cb;
            if (i == rst_at) begin
                rst     = 1'b1;
                pend_v  = 1'b0;
                m_state = S_SEARCH;
                m_exempt = 1'b1;
                m_err   = 0;
            end else begin
                if (pend_v) exp_q.push_back(pend);
                pend_v  = geo && (m_state == S_LOCKED);
                pend.x  = 10'(i - H_START);
                pend.y  = 10'(ln - V_START);
                pend.r  = cr;
                pend.g  = cg;
                pend.b  = cb;
                pend.fs = (i == H_START) && (ln == V_START);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                check("reset_outputs", 64'({vif.pix_valid, vif.frame_start, vif.locked, vif.err_cnt,
                      vif.pix_x, vif.pix_y, vif.pix_r, vif.pix_g, vif.pix_b}), 64'd0);
            end
            if (i == 2 || i == 1025) begin
                check("locked", 64'(vif.locked), 64'(m_state == S_LOCKED));
                check("err_cnt", 64'(vif.err_cnt), 64'(m_err));
            end
        end
        m_prev_len = len;
    endtask

    task automatic send_frame(input int nlines, input int short_ln, input int long_ln,
                              input int rst_ln, input bit next_b);
        int len;
        for (int ln = 0; ln < nlines; ln++) begin
            len = H_WHOLE;
            if (ln == short_ln) len = H_WHOLE - 1;
            if (ln == long_ln)  len = LONG_LEN;
            send_line(len, ln, ln == 0, ln < 2, next_b && (ln == nlines - 1),
                      (ln == rst_ln) ? 20 : -1);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: pops one expected pixel per DUT pix_valid, otherwise requires blanked outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (vif.pix_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pix_valid", 64'(vif.pix_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_pos", 64'({vif.pix_x, vif.pix_y}), 64'({e.x, e.y}));
                        check("pix_rgb", 64'({vif.pix_r, vif.pix_g, vif.pix_b}), 64'({e.r, e.g, e.b}));
                        check("frame_start", 64'(vif.frame_start), 64'(e.fs));
                    end
                end else begin
                    check("idle_outputs", 64'({vif.pix_r, vif.pix_g, vif.pix_b, vif.frame_start}), 64'd0);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.HSYNC = 1'b1;
        vif.VSYNC = 1'b1;
        vif.R = 4'd0;
        vif.G = 4'd0;
        vif.B = 4'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({vif.pix_valid, vif.frame_start, vif.locked, vif.err_cnt,
              vif.pix_x, vif.pix_y, vif.pix_r, vif.pix_g, vif.pix_b}), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Free-running lines without VSYNC, then acquire lock over three anchors
        send_line(H_WHOLE, 99, 1'b0, 1'b0, 1'b0, -1);
        send_line(H_WHOLE, 99, 1'b0, 1'b0, 1'b0, -1);
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        // Locked frame with a line one sample short, then reacquire
        send_frame(V_WHOLE, 10, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        // Locked frame with HSYNC stuck high long enough to saturate the line counter
        send_frame(V_WHOLE, -1, 7, -1, rb());
        // One frame short by a line while tracking, then reacquire
        send_frame(V_WHOLE - 1, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        // Reset pulse inside an active line while locked, then reacquire
        send_frame(V_WHOLE, -1, -1, 6, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, rb());
        send_frame(V_WHOLE, -1, -1, -1, 1'b0);

        if (pend_v) exp_q.push_back(pend);
        pend_v = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
